// File: rtl/redirect_arbiter.sv
// Picks the oldest surviving branch redirect each cycle and blocks wrong-path (younger) redirects until the ROB walk completes.
// Optional performance counters are compiled in with `define REDIRECT_ARB_PERF_EN.
module redirect_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int ROB_WIDTH  = 6,
   parameter int INFO_WIDTH = 64
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_REQ-1:0]              req_en,
   input  logic [NUM_REQ*(ROB_WIDTH+1)-1:0] req_rob_idx,
   input  logic [NUM_REQ*INFO_WIDTH-1:0]   req_info,
   input  logic                            rob_flush,
   input  logic                            flush_done,
   output logic                            out_en,
   output logic [ROB_WIDTH:0]              out_rob_idx,
   output logic [INFO_WIDTH-1:0]           out_info,
   output logic [$clog2(NUM_REQ)-1:0]      out_req_id,
   output logic                            busy,
   output logic [31:0]                     perf_redirect_cnt,
   output logic [31:0]                     perf_drop_cnt
);

   localparam int RW = ROB_WIDTH + 1;
   localparam int SW = $clog2(NUM_REQ);

   typedef enum logic [1:0] {IDLE, BLOCK, FLUSH} state_t;

   state_t                 state_q, state_d;
   logic [RW-1:0]          blk_q, blk_d;
   logic                   out_en_q;
   logic [RW-1:0]          out_rob_idx_q;
   logic [INFO_WIDTH-1:0]  out_info_q;
   logic [SW-1:0]          out_req_id_q;

   logic [RW-1:0]          idx_w  [NUM_REQ];
   logic [INFO_WIDTH-1:0]  info_w [NUM_REQ];
   logic [NUM_REQ-1:0]     survive;

   logic                   win_vld;
   logic [SW-1:0]          win_id;
   logic [RW-1:0]          win_idx;
   logic [INFO_WIDTH-1:0]  win_info;

   // MSB is the wrap bit: equal MSBs compare directly, differing MSBs invert the sense.
   function automatic logic is_older(input logic [RW-1:0] a, input logic [RW-1:0] b);
      if (a[RW-1] == b[RW-1]) return a[RW-2:0] < b[RW-2:0];
      else                    return a[RW-2:0] > b[RW-2:0];
   endfunction

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
         assign idx_w[gi]   = req_rob_idx[gi*RW +: RW];
         assign info_w[gi]  = req_info[gi*INFO_WIDTH +: INFO_WIDTH];
         assign survive[gi] = req_en[gi] & ~rob_flush & (state_q != FLUSH)
                              & ((state_q == IDLE) | is_older(idx_w[gi], blk_q));
      end
   endgenerate

   // Strictly-older replaces the current pick, so equal ages keep the lower port.
   always_comb begin
      win_vld  = 1'b0;
      win_id   = '0;
      win_idx  = '0;
      win_info = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (survive[i] && (!win_vld || is_older(idx_w[i], win_idx))) begin
            win_vld  = 1'b1;
            win_id   = SW'(i);
            win_idx  = idx_w[i];
            win_info = info_w[i];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      blk_d   = blk_q;
      if (rob_flush) begin
         state_d = FLUSH;
      end else begin
         case (state_q)
            IDLE:    if (win_vld) state_d = BLOCK;
            BLOCK:   if (!win_vld && flush_done) state_d = IDLE;
            FLUSH:   if (flush_done) state_d = IDLE;
            default: state_d = IDLE;
         endcase
         if (win_vld) blk_d = win_idx;
      end
   end

   always_comb begin
      busy = (state_q != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blk_q         <= '0;
         out_en_q      <= 1'b0;
         out_rob_idx_q <= '0;
         out_info_q    <= '0;
         out_req_id_q  <= '0;
      end else begin
         blk_q    <= blk_d;
         out_en_q <= win_vld;
         if (win_vld) begin
            out_rob_idx_q <= win_idx;
            out_info_q    <= win_info;
            out_req_id_q  <= win_id;
         end
      end
   end

   // A flush in the issue cycle must kill the redirect before the consumer sees it.
   assign out_en      = out_en_q & ~rob_flush;
   assign out_rob_idx = out_rob_idx_q;
   assign out_info    = out_info_q;
   assign out_req_id  = out_req_id_q;

`ifdef REDIRECT_ARB_PERF_EN
   logic [31:0] redir_cnt_q, redir_cnt_d;
   logic [31:0] drop_cnt_q, drop_cnt_d;
   logic [31:0] drop_inc;
   logic [32:0] drop_sum;

   always_comb begin
      drop_inc = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         drop_inc = drop_inc + {31'd0, req_en[i] & ~survive[i]};
      end
      drop_sum    = {1'b0, drop_cnt_q} + {1'b0, drop_inc};
      drop_cnt_d  = drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
      redir_cnt_d = (out_en && redir_cnt_q != 32'hFFFF_FFFF) ? redir_cnt_q + 32'd1 : redir_cnt_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         redir_cnt_q <= '0;
         drop_cnt_q  <= '0;
      end else begin
         redir_cnt_q <= redir_cnt_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   assign perf_redirect_cnt = redir_cnt_q;
   assign perf_drop_cnt     = drop_cnt_q;
`else
   assign perf_redirect_cnt = 32'd0;
   assign perf_drop_cnt     = 32'd0;
`endif

endmodule

// File: tb/tb_redirect_arbiter.sv
// Randomized and directed bench for redirect_arbiter against a modular-distance age model.
// Counter expectations follow REDIRECT_ARB_PERF_EN when defined.
module tb_redirect_arbiter;

   localparam int N  = 4;
   localparam int RW = 7;
   localparam int IW = 64;

   logic              clk = 1'b0;
   logic              rst;
   logic [N-1:0]      req_en;
   logic [N*RW-1:0]   req_rob_idx;
   logic [N*IW-1:0]   req_info;
   logic              rob_flush;
   logic              flush_done;
   logic              out_en;
   logic [RW-1:0]     out_rob_idx;
   logic [IW-1:0]     out_info;
   logic [1:0]        out_req_id;
   logic              busy;
   logic [31:0]       perf_redirect_cnt;
   logic [31:0]       perf_drop_cnt;

   redirect_arbiter #(.NUM_REQ(N), .ROB_WIDTH(6), .INFO_WIDTH(IW)) dut (
      .clk(clk), .rst(rst), .req_en(req_en), .req_rob_idx(req_rob_idx),
      .req_info(req_info), .rob_flush(rob_flush), .flush_done(flush_done),
      .out_en(out_en), .out_rob_idx(out_rob_idx), .out_info(out_info),
      .out_req_id(out_req_id), .busy(busy),
      .perf_redirect_cnt(perf_redirect_cnt), .perf_drop_cnt(perf_drop_cnt));

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // stimulus for the current cycle
   logic [N-1:0]  t_en;
   logic [RW-1:0] t_idx  [N];
   logic [IW-1:0] t_info [N];
   logic          t_rf, t_fd;

   // reference model
   bit            m_blocked, m_flushing, m_en_q;
   int            m_blk, m_rob, m_id;
   logic [IW-1:0] m_info;
   longint        m_redir, m_drop;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // a is older than b when b lies 1..63 steps ahead of a on the 128-entry circle
   function automatic bit m_older(input int a, input int b);
      int d;
      d = (b - a) & 127;
      return (d >= 1) && (d <= 63);
   endfunction

   task automatic apply();
      req_en     = t_en;
      rob_flush  = t_rf;
      flush_done = t_fd;
      for (int i = 0; i < N; i++) begin
         req_rob_idx[i*RW +: RW] = t_idx[i];
         req_info[i*IW +: IW]    = t_info[i];
      end
   endtask

   task automatic clear_inputs();
      t_en = '0; t_rf = 1'b0; t_fd = 1'b0;
      for (int i = 0; i < N; i++) begin
         t_idx[i] = '0; t_info[i] = '0;
      end
      apply();
   endtask

   task automatic model_reset();
      m_blocked = 0; m_flushing = 0; m_en_q = 0;
      m_blk = 0; m_rob = 0; m_id = 0; m_info = '0;
      m_redir = 0; m_drop = 0;
   endtask

   task automatic set_req(input int p, input logic [RW-1:0] idx);
      t_en[p]   = 1'b1;
      t_idx[p]  = idx;
      t_info[p] = {$urandom, $urandom};
   endtask

   task automatic check_outputs();
      check("out_en", {63'd0, out_en}, {63'd0, m_en_q & ~t_rf});
      check("out_rob_idx", {57'd0, out_rob_idx}, 64'(m_rob));
      check("out_info", out_info, m_info);
      check("out_req_id", {62'd0, out_req_id}, 64'(m_id));
      check("busy", {63'd0, busy}, {63'd0, m_blocked | m_flushing});
`ifdef REDIRECT_ARB_PERF_EN
      check("perf_redirect", {32'd0, perf_redirect_cnt}, 64'(m_redir));
      check("perf_drop", {32'd0, perf_drop_cnt}, 64'(m_drop));
`else
      check("perf_redirect", {32'd0, perf_redirect_cnt}, 64'd0);
      check("perf_drop", {32'd0, perf_drop_cnt}, 64'd0);
`endif
   endtask

   // one clock: drive, check against model, predict, clock, commit
   task automatic tick();
      bit surv [N];
      int win, ndrop;
      bit ok;
      apply();
      #1;
      check_outputs();
      ndrop = 0;
      win = -1;
      for (int i = 0; i < N; i++) begin
         surv[i] = t_en[i] && !t_rf && !m_flushing && (!m_blocked || m_older(int'(t_idx[i]), m_blk));
         if (t_en[i] && !surv[i]) ndrop++;
      end
      for (int w = 0; w < N; w++) begin
         ok = surv[w];
         for (int j = 0; j < N; j++)
            if (surv[j] && m_older(int'(t_idx[j]), int'(t_idx[w]))) ok = 0;
         if (ok && win < 0) win = w;
      end
      if (m_en_q && !t_rf) m_redir++;
      m_drop += ndrop;
      @(posedge clk);
      #1;
      if (t_rf) begin
         m_flushing = 1; m_blocked = 0; m_en_q = 0;
      end else if (win >= 0) begin
         m_blocked = 1; m_blk = int'(t_idx[win]); m_en_q = 1;
         m_rob = int'(t_idx[win]); m_info = t_info[win]; m_id = win;
         $display("redirect: port %0d robIdx %02h", win, t_idx[win]);
      end else begin
         m_en_q = 0;
         if (t_fd) begin
            m_flushing = 0; m_blocked = 0;
         end
      end
      clear_inputs();
   endtask

   initial begin
      int base;
      rst = 1'b1;
      clear_inputs();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_en", {63'd0, out_en}, 64'd0);
      check("rst_rob_idx", {57'd0, out_rob_idx}, 64'd0);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_perf", {32'd0, perf_redirect_cnt | perf_drop_cnt}, 64'd0);
      rst = 1'b0;

      // oldest of two in IDLE
      set_req(0, 7'h05); set_req(2, 7'h03); tick();
      check("tp1_en", {63'd0, out_en}, 64'd1);
      check("tp1_idx", {57'd0, out_rob_idx}, 64'h03);
      check("tp1_id", {62'd0, out_req_id}, 64'd2);
      check("tp1_busy", {63'd0, busy}, 64'd1);
      t_fd = 1'b1; tick();
      check("tp1_idle", {63'd0, busy}, 64'd0);

      // wrap-around age
      set_req(1, 7'h40); set_req(3, 7'h3E); tick();
      check("tp2_id", {62'd0, out_req_id}, 64'd3);
      check("tp2_idx", {57'd0, out_rob_idx}, 64'h3E);
      set_req(0, 7'h10); tick();
      check("tp3_nest", {57'd0, out_rob_idx}, 64'h10);

      // younger dropped, older nested redirect issued
      set_req(0, 7'h12); tick();
      check("tp3_drop", {63'd0, out_en}, 64'd0);
      set_req(1, 7'h0C); tick();
      check("tp3_en", {63'd0, out_en}, 64'd1);
      check("tp3_idx", {57'd0, out_rob_idx}, 64'h0C);

      // flush_done returns to IDLE, then a normal issue
      t_fd = 1'b1; tick();
      check("tp4_idle", {63'd0, busy}, 64'd0);
      set_req(0, 7'h20); tick();
      check("tp4_idx", {57'd0, out_rob_idx}, 64'h20);

      // rob_flush masks an issuing redirect, FLUSH drops everything
      t_rf = 1'b1; apply(); #1;
      check("tp5_mask", {63'd0, out_en}, 64'd0);
      tick();
      set_req(0, 7'h01); set_req(1, 7'h02); set_req(2, 7'h7F); set_req(3, 7'h00); tick();
      check("tp5_flush_drop", {63'd0, out_en}, 64'd0);
      t_fd = 1'b1; tick();
      check("tp5_idle", {63'd0, busy}, 64'd0);

      // equal robIdx tie
      set_req(1, 7'h08); set_req(3, 7'h08); tick();
      check("tp6_tie", {62'd0, out_req_id}, 64'd1);
      check("tp6_busy", {63'd0, busy}, 64'd1);

      // reset mid-BLOCK
      rst = 1'b1; #1;
      model_reset();
      check("tp6_rst_busy", {63'd0, busy}, 64'd0);
      check("tp6_rst_idx", {57'd0, out_rob_idx}, 64'd0);
      check("tp6_rst_id", {62'd0, out_req_id}, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // random traffic within a 41-entry age window that moves around the circle
      base = 0;
      for (int c = 0; c < 2000; c++) begin
         if (c % 200 == 0) base = $urandom_range(0, 127);
         for (int p = 0; p < N; p++)
            if ($urandom_range(0, 2) == 0) set_req(p, RW'((base + $urandom_range(0, 40)) & 127));
         t_rf = ($urandom_range(0, 15) == 0);
         t_fd = ($urandom_range(0, 5) == 0);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/redirect_arbiter.md
Name: redirect_arbiter

Overview:
- Selects the single oldest branch-unit redirect per cycle from NUM_REQ branch execution ports.
- Suppresses wrong-path redirects: after a redirect issues, younger requests are dropped until the rename/ROB walk reports completion.
- Sits between the branch ALUs and the backend redirect control stage.
- Feeds that stage one registered, age-correct redirect per cycle.

Parameters:
NUM_REQ, 4, number of branch requester ports
ROB_WIDTH, 6, ROB index width; robIdx carries ROB_WIDTH+1 bits (MSB = wrap/direction bit)
INFO_WIDTH, 64, opaque redirect payload width (target, taken, types)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
req_en  in  NUM_REQ  per-port redirect request valid
req_rob_idx  in  NUM_REQ*(ROB_WIDTH+1)  per-port robIdx, port i at bits [i*(ROB_WIDTH+1) +: ROB_WIDTH+1]
req_info  in  NUM_REQ*INFO_WIDTH  per-port payload
rob_flush  in  1  ROB/CSR flush (exception, interrupt, csr redirect)
flush_done  in  1  rename/ROB walk complete pulse
out_en  out  1  redirect valid
out_rob_idx  out  ROB_WIDTH+1  winner robIdx
out_info  out  INFO_WIDTH  winner payload
out_req_id  out  $clog2(NUM_REQ)  winning port
busy  out  1  state != IDLE
perf_redirect_cnt  out  32  issued redirects (optional feature)
perf_drop_cnt  out  32  dropped requests (optional feature)

Behaviour:
- Age rule: a older than b iff (a.msb==b.msb) ? a.idx<b.idx : a.idx>b.idx. Equal robIdx is not older.
- Ties between ports: lower port index wins.
- States: IDLE, BLOCK (holds blk_idx), FLUSH.
- Request filter in cycle t, request i survives iff all hold:
  - req_en[i]=1;
  - rob_flush=0;
  - state!=FLUSH;
  - state==IDLE, or req_rob_idx[i] is older than blk_idx.
- Winner = oldest survivor. Winner robIdx/info/id are registered; out_en_q=1 in cycle t+1 for exactly one cycle.
- out_en = out_en_q & ~rob_flush (combinational mask). out_rob_idx/out_info/out_req_id hold their last registered value when out_en=0.
- Transitions:
  - IDLE + winner -> BLOCK, blk_idx<=winner idx.
  - BLOCK + winner -> BLOCK, blk_idx<=winner idx. Winner is necessarily older (nested redirect).
  - BLOCK + flush_done, no winner -> IDLE.
  - BLOCK + flush_done + winner -> BLOCK with new blk_idx. The winner wins over flush_done.
  - Any state + rob_flush -> FLUSH, out_en_q<=0. rob_flush dominates all else.
  - FLUSH + flush_done (no rob_flush) -> IDLE.
  - FLUSH + rob_flush -> FLUSH.
  - flush_done in IDLE: ignored.
- Latency: request to out_en is one cycle. Back-to-back redirects are allowed every cycle while each is older than the previous.
- Wrap-around: the MSB rule alone handles it; no modulo arithmetic beyond that.
- Reset: state IDLE, blk_idx 0, out_en 0, out_rob_idx 0, out_info 0, out_req_id 0, busy 0, perf counters 0.
- Reset mid-BLOCK/FLUSH returns to IDLE immediately.

Optional Feature:
- Macro REDIRECT_ARB_PERF_EN.
- Defined:
  - perf_redirect_cnt increments by 1 per cycle where out_en=1.
  - perf_drop_cnt increments by the number of req_en bits filtered out that cycle.
  - Both counters saturate at 32'hFFFFFFFF.
- Undefined: both ports are driven constant 0 and no counter flops exist.

Test Plan:
- IDLE, req_en=4'b0101, port0 idx=7'h05, port2 idx=7'h03 -> next cycle out_en=1, out_rob_idx=7'h03, out_req_id=2, busy=1.
- Wrap: port1 idx=7'h40, port3 idx=7'h3E in IDLE -> winner port3 (7'h3E older across wrap).
- BLOCK blk_idx=7'h10, then port0 idx=7'h12 -> dropped, out_en=0 (perf_drop_cnt+1). Then port1 idx=7'h0C -> out_en=1, out_rob_idx=7'h0C, blk_idx=7'h0C.
- BLOCK + flush_done with no request -> busy=0 next cycle; then port0 idx=7'h20 -> issued normally.
- out_en_q=1 while rob_flush=1 -> out_en=0 same cycle. State FLUSH: all requests dropped until flush_done, then IDLE.
- Equal robIdx 7'h08 on ports 1 and 3 -> out_req_id=1. Assert rst mid-BLOCK -> all outputs 0, busy=0.
